rx_phyretrain: RTL
==================

# rx_phyretrain

Responder half of the LTSM PHYRETRAIN state. Consumes the partner's PHYRETRAIN start request (with its retrain encoding) from the sideband decoder, answers with PHYRETRAIN start response, resolves the local and remote retrain encodings into one exit target, and signals completion to the LTSM. Runs in parallel with the TX_PHYRETRAIN request side. Shares the sideband wrapper valid/busy handshake with it. Guards the exchange with a timeout counter.

## Interface
- SB_MSG_WIDTH, 4, width of encoded/decoded sideband message codes
- TIMEOUT_CYCLES, 8000000, cycles from entering WAIT_REQ until timeout (8 ms at 1 GHz); must be ≥ 2
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_phyretrain_en  in  1  LTSM enable for PHYRETRAIN; low forces IDLE
- i_local_msg_info  in  3  local retrain encoding (the one TX side sends): 001 TXSELFCAL, 010 SPEEDIDLE, 100 REPAIR
- i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message
- i_rx_msg_valid  in  1  qualifies i_decoded_SB_msg and i_rx_msg_info for one cycle
- i_rx_msg_info  in  3  partner retrain encoding carried in the request
- i_falling_edge_busy  in  1  sideband finished transmitting the current message
- i_tx_valid  in  1  TX_PHYRETRAIN valid; while high, o_valid_rx is held
- o_encoded_SB_msg_rx  out  SB_MSG_WIDTH  message to encode; reset 0
- o_valid_rx  out  1  message valid to wrapper; reset 0
- o_resolved_msg_info  out  3  resolved exit target, one-hot as above; reset 0
- o_phyretrain_end_rx  out  1  responder done; reset 0
- o_timeout  out  1  exchange timed out; reset 0

## Operation
- Message codes: PHYRETRAIN_START_REQ = 1, PHYRETRAIN_START_RESP = 2. Other codes are ignored.
- "req" means i_rx_msg_valid && i_decoded_SB_msg == PHYRETRAIN_START_REQ.
- States and transitions (en means i_phyretrain_en):
  - IDLE: en && req goes to SEND_RESP. en && !req goes to WAIT_REQ. Otherwise stay in IDLE.
  - WAIT_REQ: !en goes to IDLE. req goes to SEND_RESP. Counter at TIMEOUT_CYCLES-1 goes to TIMEOUT. Otherwise stay.
  - SEND_RESP: !en goes to IDLE. i_falling_edge_busy && !i_tx_valid goes to DONE. Otherwise stay.
  - DONE, TIMEOUT: !en goes to IDLE. Otherwise stay.
- Resolution priority is SPEEDIDLE > REPAIR > TXSELFCAL, applied bitwise on the OR of local and remote encodings.
  - A remote encoding that is zero or not one-hot is treated as TXSELFCAL. The same applies to the local encoding.
  - o_resolved_msg_info is captured on entry to SEND_RESP and held until IDLE.
- On entry to SEND_RESP: o_encoded_SB_msg_rx <= PHYRETRAIN_START_RESP and o_valid_rx <= 1.
- o_valid_rx clears on i_falling_edge_busy && !i_tx_valid. It is held while i_tx_valid is high.
- o_phyretrain_end_rx is 1 in DONE, o_timeout is 1 in TIMEOUT, and both are 0 elsewhere.
- In IDLE all outputs return to 0 and the counter is 0.

## Timing
- All outputs are registered.
- Request latency: req sampled at edge N (in IDLE or WAIT_REQ) gives o_valid_rx = 1, RESP code and resolved info at edge N+1.
- Completion latency: handshake-clear condition sampled at edge M (in SEND_RESP) gives o_valid_rx = 0 and o_phyretrain_end_rx = 1 at edge M+1.
- Counter:
  - Width is $clog2(TIMEOUT_CYCLES).
  - Increments each cycle in WAIT_REQ and SEND_RESP.
  - Reaching TIMEOUT_CYCLES-1 in WAIT_REQ moves to TIMEOUT.
  - In SEND_RESP the counter saturates and never times out.
  - Cleared in IDLE.
- Simultaneous events:
  - req and timeout terminal count in the same cycle: req wins.
  - en rising together with req: go straight to SEND_RESP, so the request is never lost.
- Duplicate requests in SEND_RESP, DONE or TIMEOUT are ignored; the resolved info is not re-captured.
- Enable drop mid-operation: the next edge is IDLE with all outputs 0, including a pending o_valid_rx.
- Asserting i_rst at any time forces IDLE, all outputs 0 and counter 0, asynchronously.

## Structure
- Shared LTSM package holds:
  - PHYRETRAIN_START_REQ/RESP codes
  - the retrain encodings TXSELFCAL/SPEEDIDLE/REPAIR
  - the resolution function, so TX/RX and the LTSM exit decode agree
- Sub-module ltsm_timeout_counter: enable, clear, terminal-count parameter, saturating. It is reused by other LTSM states.

## Test plan
- Reset with i_rst = 1, en = 1 and req driven -> all outputs 0. Release reset -> WAIT_REQ, no valid.
- en = 1, local 001, req with remote 100 -> next cycle o_valid_rx = 1, msg = 2, resolved = 100. Pulse busy fall with i_tx_valid = 0 -> next cycle o_valid_rx = 0, end = 1.
- Local 100, remote 010 -> resolved 010. Local 001, remote 011 (invalid) -> resolved 001.
- Busy fall while i_tx_valid = 1 -> o_valid_rx stays 1, remains in SEND_RESP. Next busy fall with i_tx_valid = 0 -> DONE.
- TIMEOUT_CYCLES = 16, no req -> o_timeout = 1 sixteen cycles after WAIT_REQ entry. Req on the terminal cycle -> SEND_RESP instead.
- Drop en while in SEND_RESP -> next cycle all outputs 0. Re-raise en -> WAIT_REQ with counter 0.

Source files
------------

// File: rtl/rx_phyretrain_pkg.sv
// Shared LTSM definitions for the PHYRETRAIN state: sideband codes, retrain
// encodings and the exit-target resolution used by TX, RX and the LTSM decode.
package rx_phyretrain_pkg;

  localparam logic [3:0] PHYRETRAIN_START_REQ  = 4'd1;
  localparam logic [3:0] PHYRETRAIN_START_RESP = 4'd2;

  localparam logic [2:0] TXSELFCAL = 3'b001;
  localparam logic [2:0] SPEEDIDLE = 3'b010;
  localparam logic [2:0] REPAIR    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REQ,
    ST_SEND_RESP,
    ST_DONE,
    ST_TIMEOUT
  } rx_state_e;

  // Zero or multi-hot encodings collapse to the least disruptive target.
  function automatic logic [2:0] sanitize_info(input logic [2:0] info);
    if ((info != 3'b000) && ((info & (info - 3'd1)) == 3'b000)) begin
      return info;
    end
    return TXSELFCAL;
  endfunction

  function automatic logic [2:0] resolve_retrain(input logic [2:0] local_info,
                                                 input logic [2:0] remote_info);
    logic [2:0] merged;
    merged = sanitize_info(local_info) | sanitize_info(remote_info);
    if ((merged & SPEEDIDLE) != 3'b000) begin
      return SPEEDIDLE;
    end
    if ((merged & REPAIR) != 3'b000) begin
      return REPAIR;
    end
    return TXSELFCAL;
  endfunction

endpackage

// File: rtl/rx_phyretrain_timeout_counter.sv
// Saturating LTSM timeout counter: counts while enabled, clears on demand and
// flags the terminal count TERMINAL-1.
module ltsm_timeout_counter #(
  parameter int TERMINAL = 8000000,
  localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_terminal
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_term;

  assign at_term    = (count_q == W'(TERMINAL - 1));
  assign o_terminal = at_term;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_en && !at_term) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_phyretrain.sv
// PHYRETRAIN responder: answers the partner's start request, resolves the exit
// target and reports completion or timeout to the LTSM.
module rx_phyretrain
  import rx_phyretrain_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_phyretrain_en,
  input  logic [2:0]              i_local_msg_info,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_rx_msg_valid,
  input  logic [2:0]              i_rx_msg_info,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_tx_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_valid_rx,
  output logic [2:0]              o_resolved_msg_info,
  output logic                    o_phyretrain_end_rx,
  output logic                    o_timeout
);

  // Wrapper handshake: o_valid_rx rises with the RESP code and stays high until
  // the sideband reports busy falling while the TX side is not also presenting.
  rx_state_e               state_q, state_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic                    valid_q, valid_d;
  logic [2:0]              res_q, res_d;
  logic                    end_q, end_d;
  logic                    timeout_q, timeout_d;

  logic req;
  logic hs_clear;
  logic cnt_terminal;

  assign req      = i_rx_msg_valid &&
                    (i_decoded_SB_msg == SB_MSG_WIDTH'(PHYRETRAIN_START_REQ));
  assign hs_clear = i_falling_edge_busy && !i_tx_valid;

  ltsm_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       ((state_q == ST_WAIT_REQ) || (state_q == ST_SEND_RESP)),
    .i_clear    (state_q == ST_IDLE),
    .o_terminal (cnt_terminal)
  );

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    valid_d = valid_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (i_phyretrain_en) begin
          state_d = req ? ST_SEND_RESP : ST_WAIT_REQ;
        end
      end
      ST_WAIT_REQ: begin
        if (!i_phyretrain_en) begin
          state_d = ST_IDLE;
        end else if (req) begin
          state_d = ST_SEND_RESP;
        end else if (cnt_terminal) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_SEND_RESP: begin
        if (!i_phyretrain_en) begin
          state_d = ST_IDLE;
        end else if (hs_clear) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (!i_phyretrain_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_SEND_RESP) && (state_q != ST_SEND_RESP)) begin
      msg_d   = SB_MSG_WIDTH'(PHYRETRAIN_START_RESP);
      valid_d = 1'b1;
      res_d   = resolve_retrain(i_local_msg_info, i_rx_msg_info);
    end
    if ((state_q == ST_SEND_RESP) && (state_d == ST_DONE)) begin
      valid_d = 1'b0;
    end
    if (state_d == ST_IDLE) begin
      msg_d   = '0;
      valid_d = 1'b0;
      res_d   = 3'b000;
    end

    end_d     = (state_d == ST_DONE);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      msg_q     <= '0;
      valid_q   <= 1'b0;
      res_q     <= 3'b000;
      end_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      end_q     <= end_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_encoded_SB_msg_rx = msg_q;
  assign o_valid_rx          = valid_q;
  assign o_resolved_msg_info = res_q;
  assign o_phyretrain_end_rx = end_q;
  assign o_timeout           = timeout_q;

endmodule
